// File: rtl/range_error_reporter.sv
// -----------------------------------------------------------------------------
// range_error_reporter
//
// Downstream stage of the vector range checker. It captures one checked vector
// (N elements of W bits plus an N-bit out-of-range mask), walks the mask in
// ascending index order and emits one (index, value) record per flagged element
// over a valid/ready stream. When the walk finishes it publishes the vector's
// error count and pulses done for one cycle.
//
// Optional feature: define RANGE_REPORT_SUMMARY_EN to append one summary record
// (index all ones, value = error count, last = 1) after the error records. In
// that build, error records never assert out_last.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high reset
//   in_valid   vector and mask presented by the upstream checker
//   in_ready   block can capture a vector (IDLE only)
//   vec_flat   element i occupies bits [i*W+W-1 : i*W]
//   err_mask   per-element out-of-range flag
//   out_valid  record presented
//   out_ready  consumer accepts the record
//   out_index  element index of the record
//   out_value  element value of the record
//   out_last   final record of the current vector
//   err_count  number of flagged elements in the last completed vector
//   done       one-cycle pulse when the vector is fully reported
// -----------------------------------------------------------------------------
module range_error_reporter #(
    parameter int N     = 12,
    parameter int W     = 8,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   vec_flat,
    input  logic [N-1:0]     err_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [W-1:0]     out_value,
    output logic             out_last,
    output logic [IDX_W-1:0] err_count,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        EMIT   = 3'd2,
        FINISH = 3'd3
`ifdef RANGE_REPORT_SUMMARY_EN
        , SUMMARY = 3'd4
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic [N-1:0][W-1:0]     vec_q;
    logic [N-1:0]            mask_q;

    logic                    in_ready_d, out_valid_d, out_last_d, done_d;
    logic [IDX_W-1:0]        out_index_d, err_count_d;
    logic [W-1:0]            out_value_d;
    logic                    capture;
    logic                    end_walk;

`ifndef RANGE_REPORT_SUMMARY_EN
    // A record is the last one when no flagged element remains above it.
    logic higher_set;

    always_comb begin
        higher_set = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i > int'(idx_q) && mask_q[i]) higher_set = 1'b1;
        end
    end
`endif

    // Next-state and next-output logic. Every output is a register, so this
    // block computes the values they take at the next edge.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_index_d = out_index;
        out_value_d = out_value;
        out_last_d  = out_last;
        err_count_d = err_count;
        done_d      = 1'b0;
        capture     = 1'b0;
        end_walk    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready) begin
                    capture    = 1'b1;
                    cnt_d      = '0;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SCAN;
                end
            end

            SCAN: begin
                if (mask_q[idx_q]) begin
                    out_index_d = idx_q;
                    out_value_d = vec_q[idx_q];
`ifdef RANGE_REPORT_SUMMARY_EN
                    out_last_d  = 1'b0;
`else
                    out_last_d  = !higher_set;
`endif
                    cnt_d       = cnt_q + 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = EMIT;
                end else if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    end_walk = 1'b1;
                end
            end

            EMIT: begin
                // Outputs hold their registered values until the handshake.
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        end_walk = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SCAN;
                    end
                end
            end

`ifdef RANGE_REPORT_SUMMARY_EN
            SUMMARY: begin
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = FINISH;
                end
            end
`endif

            FINISH: begin
                err_count_d = cnt_q;
                done_d      = 1'b1;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Leaving the walk: either straight to FINISH or via the summary record.
        if (end_walk) begin
`ifdef RANGE_REPORT_SUMMARY_EN
            state_d     = SUMMARY;
            out_valid_d = 1'b1;
            out_index_d = '1;
            out_value_d = W'(cnt_q);
            out_last_d  = 1'b1;
`else
            state_d     = FINISH;
`endif
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_index <= '0;
            out_value <= '0;
            out_last  <= 1'b0;
            err_count <= '0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_index <= out_index_d;
            out_value <= out_value_d;
            out_last  <= out_last_d;
            err_count <= err_count_d;
            done      <= done_d;
        end
    end

    // NOTE: the captured vector and mask have no reset; they are only read
    // after a capture has loaded them, so resetting them would buy nothing.
    always_ff @(posedge clock) begin
        if (capture) begin
            vec_q  <= vec_flat;
            mask_q <= err_mask;
        end
    end

endmodule

// File: tb/tb_range_error_reporter.sv
// -----------------------------------------------------------------------------
// tb_range_error_reporter
//
// Self-checking bench for range_error_reporter. A reference model turns each
// (vector, mask) pair into the expected ordered list of records and error
// count; a driver task feeds the vector, plays the consumer (always ready,
// stall-first-record, or random ready) and collects what the DUT emits.
// Build with RANGE_REPORT_SUMMARY_EN defined to check the summary-record build.
// -----------------------------------------------------------------------------
module tb_range_error_reporter;

    localparam int N     = 12;
    localparam int W     = 8;
    localparam int IDX_W = 4;

`ifdef RANGE_REPORT_SUMMARY_EN
    localparam int SUMM = 1;
`else
    localparam int SUMM = 0;
`endif

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [W-1:0]     val;
        logic             last;
    } rec_t;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   vec;
    logic [N-1:0]     mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [W-1:0]     out_value;
    logic             out_last;
    logic [IDX_W-1:0] err_count;
    logic             done;

    int checks = 0;
    int errors = 0;

    rec_t got_q[$];
    rec_t exp_q[$];
    int   exp_total;
    int   done_cycle;
    int   done_pulses;
    logic [IDX_W-1:0] err_at_done;
    int   first_hold;
    int   unstable;
    int   poke_bad;
    bit   timeout;

    range_error_reporter #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vec_flat  (vec),
        .err_mask  (mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_value (out_value),
        .out_last  (out_last),
        .err_count (err_count),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: flagged elements in ascending order; the last one
    // carries out_last, or a trailing summary record does when enabled.
    function automatic void build_model(input logic [N*W-1:0] v, input logic [N-1:0] m);
        rec_t r;
        int   seen;
        exp_q.delete();
        exp_total = $countones(m);
        seen = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                seen++;
                r.idx  = IDX_W'(i);
                r.val  = v[i*W +: W];
                r.last = (SUMM == 0) && (seen == exp_total);
                exp_q.push_back(r);
            end
        end
        if (SUMM != 0) begin
            r.idx  = '1;
            r.val  = W'(exp_total);
            r.last = 1'b1;
            exp_q.push_back(r);
        end
    endfunction

    // mode 0: always ready; mode 1: stall first record stall_n cycles;
    // mode 2: random ready. poke drives a different vector while busy.
    task automatic send_vector(input logic [N*W-1:0] v, input logic [N-1:0] m,
                               input int mode, input int stall_n, input bit poke);
        int   c;
        int   after;
        rec_t cur;
        rec_t prev;
        bit   prev_v;
        bit   prev_hs;
        got_q.delete();
        done_cycle  = -1;
        done_pulses = 0;
        err_at_done = '0;
        first_hold  = 0;
        unstable    = 0;
        poke_bad    = 0;
        timeout     = 1'b0;
        prev_v      = 1'b0;
        prev_hs     = 1'b0;
        prev        = '0;
        out_ready   = 1'b0;
        c = 0;
        @(negedge clock);
        while (!in_ready && c < 50) begin
            @(negedge clock);
            c++;
        end
        if (!in_ready) begin
            timeout = 1'b1;
            return;
        end
        vec = v; mask = m; in_valid = 1'b1;
        @(negedge clock);               // capture edge has passed: cycle 0
        in_valid = 1'b0; vec = '0; mask = '0;
        c = 0;
        after = -1;
        while (c < 400 && (after < 0 || c < after)) begin
            @(negedge clock);
            c++;
            cur.idx = out_index; cur.val = out_value; cur.last = out_last;
            if (done) begin
                done_pulses++;
                if (done_cycle < 0) begin
                    done_cycle  = c;
                    err_at_done = err_count;
                    after       = c + 3;
                end
            end
            if (out_valid) begin
                if (prev_v && !prev_hs && cur !== prev) unstable++;
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (got_q.size() != 0) || (first_hold >= stall_n);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                if (!out_ready && got_q.size() == 0) first_hold++;
                if (out_ready) got_q.push_back(cur);
                prev_hs = out_ready;
            end else begin
                out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                prev_hs   = 1'b0;
            end
            prev_v = out_valid;
            prev   = cur;
            if (poke) begin
                in_valid = (c >= 2 && c <= 8);
                vec      = ~v;
                mask     = ~m;
                if (in_valid && in_ready) poke_bad++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (done_cycle < 0) timeout = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; vec = '0; mask = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({in_ready, out_valid, out_last, done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got ready/valid/last/done=%b%b%b%b, expected 1000",
                     in_ready, out_valid, out_last, done);
        end
        checks++;
        if (out_index !== '0 || out_value !== '0 || err_count !== '0) begin
            errors++;
            $display("FAIL reset_data: got index=%0d value=%h count=%0d, expected 0 0 0",
                     out_index, out_value, err_count);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            checks++;
            if ({out_valid, in_ready, done} !== 3'b010) begin
                errors++;
                $display("FAIL idle_cycle%0d: got valid/ready/done=%b%b%b, expected 010",
                         i, out_valid, in_ready, done);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic check_run(input string name);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: got no done pulse within budget, expected one", name);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_records: got %0d records, expected %0d", name, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s_rec%0d: got idx=%0d val=%h last=%b, expected idx=%0d val=%h last=%b",
                             name, i, got_q[i].idx, got_q[i].val, got_q[i].last,
                             exp_q[i].idx, exp_q[i].val, exp_q[i].last);
                end
            end
        end
        checks++;
        if (err_at_done !== IDX_W'(exp_total)) begin
            errors++;
            $display("FAIL %s_err_count: got %0d, expected %0d", name, err_at_done, exp_total);
        end
        checks++;
        if (done_pulses !== 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d, expected 1", name, done_pulses);
        end
    endtask

    task automatic test_mixed();
        logic [N*W-1:0] v;
        logic [N-1:0]   m;
        for (int i = 0; i < N; i++) v[i*W +: W] = 8'h55;
        v[8*W +: W]  = 8'hD4;
        v[11*W +: W] = 8'h57;
        m = 12'b0110_1111_1111;
        build_model(v, m);
        send_vector(v, m, 0, 0, 1'b0);
        check_run("mixed");
    endtask

    task automatic test_zero_mask();
        logic [N*W-1:0] v;
        v = {$urandom, $urandom, $urandom};
        build_model(v, '0);
        send_vector(v, '0, 0, 0, 1'b0);
        check_run("zero");
        checks++;
        if (done_cycle !== N + 1 + SUMM) begin
            errors++;
            $display("FAIL zero_done_latency: got %0d cycles after capture, expected %0d",
                     done_cycle, N + 1 + SUMM);
        end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] v;
        v = {$urandom, $urandom, $urandom};
        build_model(v, 12'h801);
        send_vector(v, 12'h801, 1, 5, 1'b0);
        check_run("stall");
        checks++;
        if (first_hold !== 5) begin
            errors++;
            $display("FAIL stall_hold: got first record held %0d cycles, expected 5", first_hold);
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL stall_stable: got %0d changes while stalled, expected 0", unstable);
        end
    endtask

    task automatic test_all_set();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(i);
        build_model(v, 12'hFFF);
        send_vector(v, 12'hFFF, 0, 0, 1'b1);
        check_run("allset");
        checks++;
        if (poke_bad !== 0) begin
            errors++;
            $display("FAIL allset_busy_ready: got in_ready=1 %0d times while busy, expected 0", poke_bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [N*W-1:0] v;
        int c;
        int rec;
        v = {$urandom, $urandom, $urandom};
        @(negedge clock);
        vec = v; mask = 12'hFFF; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rec = 0;
        c = 0;
        while (c < 100) begin
            @(negedge clock);
            c++;
            if (out_valid && rec == 2) break;
            out_ready = out_valid;
            if (out_valid) rec++;
        end
        out_ready = 1'b0;
        checks++;
        if (!(out_valid === 1'b1 && out_index === 4'd2)) begin
            errors++;
            $display("FAIL rstmid_third: got valid=%b idx=%0d, expected valid=1 idx=2", out_valid, out_index);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({out_valid, in_ready, done} !== 3'b010) begin
            errors++;
            $display("FAIL rstmid_abort: got valid/ready/done=%b%b%b, expected 010", out_valid, in_ready, done);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet%0d: got done=%b valid=%b, expected 0 0", i, done, out_valid);
            end
        end
        v = {$urandom, $urandom, $urandom};
        build_model(v, 12'h005);
        send_vector(v, 12'h005, 0, 0, 1'b0);
        check_run("rstmid_next");
    endtask

    task automatic test_random();
        logic [N*W-1:0] v;
        logic [N-1:0]   m;
        for (int t = 0; t < 25; t++) begin
            v = {$urandom, $urandom, $urandom};
            m = N'($urandom);
            if (t % 8 == 3) m = '1;
            if (t % 8 == 6) m = '0;
            build_model(v, m);
            send_vector(v, m, 2, 0, 1'b0);
            check_run($sformatf("rand%0d", t));
            checks++;
            if (unstable !== 0) begin
                errors++;
                $display("FAIL rand%0d_stable: got %0d changes while stalled, expected 0", t, unstable);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; vec = '0; mask = '0;
        test_reset();
        test_idle();
        test_mixed();
        test_zero_mask();
        test_backpressure();
        test_all_set();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
